regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the register file's single write port (Write_register/Write_data/RegWrite) between two
//  writeback requesters: req0 = ALU writeback, req1 = memory/load writeback.
//  Each requester has a 1-entry buffer; a round-robin arbiter drains one buffered write per cycle
//  into a registered output stage that drives the register file directly.
//  Also exports a pending-write mask for hazard/stall logic.
// PARAMETERS
//  DATA_W     32  write data width
//  ADDR_W     5   register index width; pend_mask width = 2**ADDR_W
//  ZERO_SKIP  1   1: writes to register 0 are accepted and discarded (wr_en stays 0)
// PORTS
//  clk         in   1          clock, all state updates on posedge
//  rst_n       in   1          asynchronous active-low reset
//  req0_valid  in   1          requester 0 has a write
//  req0_ready  out  1          requester 0 buffer can accept this cycle
//  req0_reg    in   ADDR_W     requester 0 destination register
//  req0_data   in   DATA_W     requester 0 write data
//  req1_valid  in   1          requester 1 has a write
//  req1_ready  out  1          requester 1 buffer can accept this cycle
//  req1_reg    in   ADDR_W     requester 1 destination register
//  req1_data   in   DATA_W     requester 1 write data
//  wr_en       out  1          to register file RegWrite
//  wr_reg      out  ADDR_W     to Write_register
//  wr_data     out  DATA_W     to Write_data
//  last_grant  out  1          requester granted most recently (the rr pointer is its inverse)
//  pend_mask   out  2**ADDR_W  bit r=1: a write to r is buffered or in the output stage
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - buf_vld0/1=0, rr_ptr=0, wr_en=0, wr_reg=0, wr_data=0, last_grant=1, pend_mask=0.
//   - req*_ready forced 0 while rst_n=0.
//   - Reset mid-operation: buffered and in-flight writes are discarded; wr_en drops immediately.
//  State: per requester i: buf_vld_i, buf_reg_i, buf_data_i; rr_ptr (1 bit); output stage registers.
//  Arbitration (combinational from registered state only):
//   - grant_i = buf_vld_i & (!buf_vld_other | rr_ptr==i).
//   - At most one grant per cycle.
//  Ready:
//   - reqi_ready = rst_n & (!buf_vld_i | grant_i).
//   - Ready never depends on valid; accept = valid & ready.
//  On posedge:
//   - Granted buffer moves to the output stage.
//   - Output stage: wr_en <= !(ZERO_SKIP && buf_reg==0), wr_reg <= buf_reg, wr_data <= buf_data.
//   - No grant: wr_en <= 0; wr_reg/wr_data hold their values.
//   - Accept into buffer i: buf_vld_i<=1 and capture reg/data.
//   - Granted buffer that is not refilled clears (buf_vld_i<=0).
//   - Drain and refill of the same buffer in one edge is legal.
//   - After a grant to i: rr_ptr <= ~i, last_grant <= i. No grant: rr_ptr and last_grant unchanged.
//  Latency and throughput:
//   - Accept at edge k -> buffered -> granted in cycle k..k+1 -> wr_en=1 in the cycle after edge
//     k+1 -> register file write at edge k+2.
//   - Minimum 2 edges accept-to-write when uncontended.
//   - One write per cycle aggregate.
//   - A requester streams 1/cycle when the other is idle.
//   - Under contention: strict alternation; each requester waits at most 1 extra cycle.
//  Ordering:
//   - Writes from one requester reach the register file in acceptance order.
//   - Both buffers targeting the same register: the grant order (rr) decides; the later grant wins.
//  Output stage has no backpressure; the register file always accepts.
//  pend_mask:
//   - OR of decoded buf_reg_i (if buf_vld_i) and wr_reg (if wr_en); combinational from state.
//   - Bit 0 is never set when ZERO_SKIP=1.
// TESTING
//  1 Reset: rst_n=0 with req0_valid=1 -> ready=0, wr_en=0, pend_mask=0.
//    After release, ready=1 within the same cycle.
//  2 Single write: req0 r5=32'hDEAD_BEEF accepted at edge k -> pend_mask[5]=1 after k;
//    wr_en=1, wr_reg=5 after edge k+1; regfile r5 updated at edge k+2.
//  3 Contention: both valid every cycle, req0 -> r1, req1 -> r2 for 8 cycles.
//    Writes alternate 0,1,0,1,... (rr_ptr=0 after reset); no lost or duplicated data.
//  4 Streaming: req1 alone, 4 back-to-back writes r8..r11 -> req1_ready stays 1;
//    wr_en high 4 consecutive cycles, order r8..r11.
//  5 Zero reg: req0 write r0=32'h1234 -> accepted, wr_en stays 0, pend_mask=0;
//    the next write follows normally.
//  6 Mid-op reset: drop rst_n with both buffers full and wr_en=1 -> wr_en=0 asynchronously.
//    After release, no stale write ever appears.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Purpose     : shares the register file's single write port between ALU writeback (req0) and
//               load writeback (req1) using one buffer per requester and a round-robin pick.
// Latency     : accept -> register-file write in 2 edges when uncontended; 1 write/cycle aggregate.
// Backpressure: reqN_ready drops only while buffer N holds a write that is not granted this cycle.
//               The output stage never stalls, because the register file always accepts.
// Ports:
//   clk, rst_n                clock and asynchronous active-low reset
//   reqN_valid/ready/reg/data requester N handshake, destination register and write data
//   wr_en, wr_reg, wr_data    registered write port driving the register file
//   last_grant                requester granted most recently
//   pend_mask                 one bit per register; set while a write to it is buffered or in flight
module regfile_wr_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [ADDR_W-1:0]        req0_reg,
  input  logic [DATA_W-1:0]        req0_data,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [ADDR_W-1:0]        req1_reg,
  input  logic [DATA_W-1:0]        req1_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_reg,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     last_grant,
  output logic [(2**ADDR_W)-1:0]   pend_mask
);

  logic              buf_vld0, buf_vld1;
  logic [ADDR_W-1:0] buf_reg0, buf_reg1;
  logic [DATA_W-1:0] buf_data0, buf_data1;
  logic              rr_ptr;
  logic              grant0, grant1;
  logic              acc0, acc1;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  // A write to register 0 is swallowed when ZERO_SKIP is set: it still flows through the
  // buffer and arbitration, so ordering is unaffected, but it never raises wr_en or pend_mask.
  function automatic logic is_real_write(input logic [ADDR_W-1:0] r);
    return !(ZERO_SKIP && (r == '0));
  endfunction

  // The round-robin pointer always points away from the last winner, so it is kept as the
  // inverse of last_grant instead of in a second flop that could drift out of step.
  assign rr_ptr = ~last_grant;

  assign grant0 = buf_vld0 & (~buf_vld1 | (rr_ptr == 1'b0));
  assign grant1 = buf_vld1 & (~buf_vld0 | (rr_ptr == 1'b1));

  // Ready is a function of state and reset only, so a buffer being drained can be refilled
  // on the same edge without any combinational path from valid.
  assign req0_ready = rst_n & (~buf_vld0 | grant0);
  assign req1_ready = rst_n & (~buf_vld1 | grant1);

  assign acc0 = req0_valid & req0_ready;
  assign acc1 = req1_valid & req1_ready;

  assign sel_reg  = grant0 ? buf_reg0  : buf_reg1;
  assign sel_data = grant0 ? buf_data0 : buf_data1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld0  <= 1'b0;
      buf_reg0  <= '0;
      buf_data0 <= '0;
    end else if (acc0) begin
      buf_vld0  <= 1'b1;
      buf_reg0  <= req0_reg;
      buf_data0 <= req0_data;
    end else if (grant0) begin
      buf_vld0  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld1  <= 1'b0;
      buf_reg1  <= '0;
      buf_data1 <= '0;
    end else if (acc1) begin
      buf_vld1  <= 1'b1;
      buf_reg1  <= req1_reg;
      buf_data1 <= req1_data;
    end else if (grant1) begin
      buf_vld1  <= 1'b0;
    end
  end

  // Output stage: without a grant only wr_en drops; wr_reg/wr_data keep their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_reg     <= '0;
      wr_data    <= '0;
      last_grant <= 1'b1;
    end else if (grant0 | grant1) begin
      wr_en      <= is_real_write(sel_reg);
      wr_reg     <= sel_reg;
      wr_data    <= sel_data;
      last_grant <= grant1;
    end else begin
      wr_en      <= 1'b0;
    end
  end

  always_comb begin
    pend_mask = '0;
    if (buf_vld0 && is_real_write(buf_reg0)) pend_mask[buf_reg0] = 1'b1;
    if (buf_vld1 && is_real_write(buf_reg1)) pend_mask[buf_reg1] = 1'b1;
    if (wr_en)                               pend_mask[wr_reg]   = 1'b1;
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_reg, req1_reg;
  logic [31:0] req0_data, req1_data;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic        last_grant;
  logic [31:0] pend_mask;

  regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(5), .ZERO_SKIP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg(req0_reg), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg(req1_reg), .req1_data(req1_data),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .last_grant(last_grant), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register-file view of r5 as the write port commits it.
  logic [31:0] rf5;
  always @(posedge clk) if (rst_n && wr_en && wr_reg == 5'd5) rf5 <= wr_data;

  // Reference model: each requester's accepted non-r0 writes, in acceptance order, plus a
  // count of outstanding writes per register for the pending mask.
  logic [36:0] q0[$];
  logic [36:0] q1[$];
  int          cnt[32];
  int          src_log[$];
  int          cyc_log[$];
  int          reg_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic record_accept(input int src, input logic [4:0] r, input logic [31:0] d);
    if (r != 5'd0) begin
      if (src == 0) q0.push_back({r, d});
      else          q1.push_back({r, d});
      cnt[r]++;
    end
  endtask

  task automatic flush_model();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 32; i++) cnt[i] = 0;
  endtask

  task automatic clear_logs();
    src_log.delete();
    cyc_log.delete();
    reg_log.delete();
  endtask

  // Called just after a negedge; presents one cycle of stimulus and returns at the next negedge.
  task automatic drive(input bit v0, input logic [4:0] r0, input logic [31:0] d0,
                       input bit v1, input logic [4:0] r1, input logic [31:0] d1,
                       output bit a0, output bit a1);
    req0_valid = v0; req0_reg = r0; req0_data = d0;
    req1_valid = v1; req1_reg = r1; req1_data = d1;
    #1;
    a0 = v0 && req0_ready;
    a1 = v1 && req1_ready;
    @(posedge clk);
    if (a0) record_accept(0, r0, d0);
    if (a1) record_accept(1, r1, d1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit a0, a1;
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a0, a1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush_model();
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #2 clear_logs();
  endtask

  // Monitor: compares every committed write with the head of the granted requester's queue
  // and checks the pending mask against outstanding-write counts.
  initial begin
    bit          prev_vld;
    logic [4:0]  prev_reg;
    logic [31:0] em;
    logic [36:0] head;
    prev_vld = 1'b0;
    prev_reg = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_wr_en", {63'd0, wr_en}, 64'd0);
        check("reset_pend_mask", {32'd0, pend_mask}, 64'd0);
        prev_vld = 1'b0;
      end else begin
        if (prev_vld) cnt[prev_reg]--;
        em = '0;
        for (int r = 0; r < 32; r++) if (cnt[r] > 0) em[r] = 1'b1;
        check("pend_mask", {32'd0, pend_mask}, {32'd0, em});
        prev_vld = wr_en;
        prev_reg = wr_reg;
        if (wr_en) begin
          checks++;
          if ((last_grant == 1'b0 && q0.size() == 0) || (last_grant == 1'b1 && q1.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_write: got src=%0d r%0d=%0h expected no write", last_grant, wr_reg, wr_data);
          end else begin
            head = (last_grant == 1'b0) ? q0.pop_front() : q1.pop_front();
            if ({wr_reg, wr_data} !== head) begin
              errors++;
              $display("FAIL write_src%0d: got r%0d=%0h expected r%0d=%0h", last_grant, wr_reg, wr_data, head[36:32], head[31:0]);
            end
          end
          src_log.push_back(int'(last_grant));
          cyc_log.push_back(cyc);
          reg_log.push_back(int'(wr_reg));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a0, a1;
    logic [31:0] d;
    flush_model();
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 32'h55;
    req1_valid = 1'b0; req1_reg = 5'd0; req1_data = 32'h0;

    // Reset state with valid asserted
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_req0_ready", {63'd0, req0_ready}, 64'd0);
    check("rst_req1_ready", {63'd0, req1_ready}, 64'd0);
    check("rst_wr_en", {63'd0, wr_en}, 64'd0);
    check("rst_wr_reg", {59'd0, wr_reg}, 64'd0);
    check("rst_wr_data", {32'd0, wr_data}, 64'd0);
    check("rst_last_grant", {63'd0, last_grant}, 64'd1);
    check("rst_pend_mask", {32'd0, pend_mask}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_release", {63'd0, req0_ready}, 64'd1);
    req0_valid = 1'b0;
    @(negedge clk);

    // Single write r5
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, a0, a1);
    check("single_accept", {63'd0, a0}, 64'd1);
    #2;
    check("single_pend5", {63'd0, pend_mask[5]}, 64'd1);
    check("single_wr_en_k", {63'd0, wr_en}, 64'd0);
    idle(1);
    #2;
    check("single_wr_en_k1", {63'd0, wr_en}, 64'd1);
    check("single_wr_reg", {59'd0, wr_reg}, 64'd5);
    check("single_wr_data", {32'd0, wr_data}, 64'hDEAD_BEEF);
    idle(1);
    #2;
    check("single_rf5", {32'd0, rf5}, 64'hDEAD_BEEF);
    check("single_wr_en_k2", {63'd0, wr_en}, 64'd0);
    check("single_pend5_clear", {63'd0, pend_mask[5]}, 64'd0);

    // Contention: alternation starting with requester 0 after reset
    do_reset();
    for (int i = 0; i < 8; i++)
      drive(1'b1, 5'd1, 32'h1000 + i, 1'b1, 5'd2, 32'h2000 + i, a0, a1);
    idle(4);
    #2;
    check("contend_count", src_log.size(), 9);
    for (int i = 0; i < src_log.size() && i < 9; i++)
      check($sformatf("contend_src%0d", i), src_log[i], i % 2);
    check("contend_drained", q0.size() + q1.size(), 0);

    // Streaming from requester 1 alone
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(8 + i), $urandom, a0, a1);
      check($sformatf("stream_ready%0d", i), {63'd0, a1}, 64'd1);
    end
    idle(3);
    #2;
    check("stream_count", src_log.size(), 4);
    for (int i = 1; i < reg_log.size() && i < 4; i++) begin
      check($sformatf("stream_reg%0d", i), reg_log[i], 8 + i);
      check($sformatf("stream_consec%0d", i), cyc_log[i] - cyc_log[i-1], 1);
    end

    // Register 0 write is swallowed; the following write is unaffected
    clear_logs();
    drive(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0, a0, a1);
    check("zero_accept", {63'd0, a0}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      #2;
      check("zero_wr_en", {63'd0, wr_en}, 64'd0);
      check("zero_pend", {32'd0, pend_mask}, 64'd0);
      idle(1);
    end
    drive(1'b1, 5'd7, 32'h7777, 1'b0, 5'd0, 32'd0, a0, a1);
    idle(3);
    #2;
    check("zero_next_count", src_log.size(), 1);
    if (reg_log.size() > 0) check("zero_next_reg", reg_log[0], 7);

    // Reset mid-operation with both buffers full and a write in flight
    for (int i = 0; i < 4; i++)
      drive(1'b1, 5'd3, 32'h3000 + i, 1'b1, 5'd4, 32'h4000 + i, a0, a1);
    #1;
    check("midrst_pre_wr_en", {63'd0, wr_en}, 64'd1);
    rst_n = 1'b0;
    flush_model();
    #1;
    check("midrst_wr_en_async", {63'd0, wr_en}, 64'd0);
    check("midrst_pend", {32'd0, pend_mask}, 64'd0);
    check("midrst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #2 clear_logs();
    idle(5);
    #2;
    check("midrst_no_stale", src_log.size(), 0);

    // Random traffic with frequent register collisions and occasional r0
    for (int i = 0; i < 400; i++) begin
      d = $urandom;
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), d,
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), ~d, a0, a1);
    end
    idle(5);
    #2;
    check("random_drained", q0.size() + q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
